m_rb_stage: RTL and testbench
=============================

# m_rb_stage

Parametrised MEM→RB (memory to register-writeback) pipeline stage register with valid/ready flow control, flush, optional skid buffering and x0 write suppression. It sits between the memory stage and the register-file writeback mux. It carries the writeback select, write enable, immediate, load data, ALU result, PC, and rd/rs1/rs2 addresses. Unlike a free-running stage register, it can stall, drop squashed instructions and break the combinational ready path.

## Interface
- XLEN, 32, width of imm, mem_rdata, alu_result, pc
- REG_AW, 5, register address width (rd, rs1, rs2)
- WBSEL_W, 2, width of writeback-select field
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all held and incoming entries
- in_valid  in  1  MEM-side entry valid
- in_ready  out  1  stage can accept this cycle
- in_wbsel, in_rd_wen, in_imm, in_mem_rdata, in_alu_result, in_pc, in_rd_waddr, in_rs1_raddr, in_rs2_raddr  in  WBSEL_W/1/XLEN/XLEN/XLEN/XLEN/REG_AW/REG_AW/REG_AW  payload
- out_valid  out  1  RB-side entry valid
- out_ready  in  1  RB consumes this cycle
- out_wbsel … out_rs2_raddr  out  same widths  payload of head entry
- out_rd_wen  out  1  qualified write enable
- occupancy  out  2  held entries (0..2; max 1 when SKID=0)

## Operation
- Accept when in_valid && in_ready && !flush. Transfer out when out_valid && out_ready.
- Storage: main entry (drives outputs) plus skid entry (SKID=1 only). Each entry has a valid bit.
- Qualified enable: out_rd_wen = main_valid && main_rd_wen && (main_rd_waddr != 0). x0 is never written. Enable is forced 0 whenever out_valid = 0.
- SKID=0: in_ready = !main_valid || out_ready. Accept loads main. Transfer without accept clears main_valid.
- SKID=1: in_ready = !skid_valid (register-driven, no path from out_ready).
  - Accept with main empty, or main transferring and skid empty: load main.
  - Accept with main full and not transferring: load skid.
  - Transfer with skid full: main <= skid, skid_valid <= 0. A same-cycle accept is impossible because in_ready = 0.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.
- flush: next cycle main_valid = skid_valid = 0. An entry presented in the flush cycle is not accepted. An out transfer in the flush cycle still counts as consumed.
- Payload registers load only on accept or skid move; they hold otherwise. Valid bits alone define liveness.
- occupancy = main_valid + skid_valid.

## Timing
- Reset (rst=1 at edge): main_valid = skid_valid = 0. All payload registers = 0. Outputs next cycle: out_valid = 0, out_rd_wen = 0, all out_* payload = 0, occupancy = 0, in_ready = 1.
- rst dominates flush and all handshakes. Reset mid-stream discards every held entry.
- Latency: accept at edge N → out_valid from edge N, i.e. visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready = 1, in both SKID modes.
- SKID=1 stall: out_ready drops in cycle k while in_valid is high → the cycle-k entry goes to skid. in_ready = 0 from cycle k+1 until the edge after the first transfer.
- All outputs are register-driven, except SKID=0 in_ready, which depends combinationally on out_ready.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, in_rd_waddr=3 → out_valid=0, out_rd_wen=0, occupancy=0, in_ready=1 during and after reset.
- Streaming: SKID=1, out_ready=1, push pc=0x100,0x104,0x108 on consecutive cycles → out_pc 0x100,0x104,0x108 on the next 3 cycles, each one cycle after its accept.
- Skid stall: SKID=1, push A,B,C back-to-back, out_ready=0 from B's cycle for 3 cycles → occupancy 2, in_ready=0, C held at input. Release → A, B, C emitted in order, none dropped.
- x0 suppression: in_rd_wen=1, in_rd_waddr=0, alu_result=0xDEADBEEF → out_valid=1, out_rd_wen=0. Same with rd_waddr=5 → out_rd_wen=1.
- Flush: occupancy 2 plus in_valid=1, assert flush 1 cycle → next cycle out_valid=0, occupancy=0. The flushed-cycle input never appears.
- SKID=0 backpressure: main full, out_ready=0 → in_ready=0 in the same cycle. out_ready=1 with in_valid → in_ready=1, new entry replaces the old at the edge.

Source files
------------

// File: rtl/m_rb_stage.sv
// ---------------------------------------------------------------------------
// m_rb_stage
// MEM -> RB (memory to register-writeback) pipeline stage register.
// This stage sits between the memory stage and the register-file writeback
// mux. It supports valid/ready flow control, flush, x0 write suppression and
// an optional two-entry skid buffer.
//
// Parameters
//   XLEN    : width of imm, mem_rdata, alu_result and pc
//   REG_AW  : register address width (rd, rs1, rs2)
//   WBSEL_W : width of the writeback-select field
//   SKID    : 1 = two-entry skid buffer, registered in_ready
//             0 = single register, in_ready combinational on out_ready
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   flush             : squash all held entries and the incoming entry
//   in_valid/in_ready : MEM-side handshake
//   in_*              : MEM-side payload
//   out_valid/out_ready : RB-side handshake
//   out_*             : payload of the head entry
//   out_rd_wen        : qualified write enable (never set for x0)
//   occupancy         : number of held entries (0..2)
// ---------------------------------------------------------------------------
module m_rb_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int WBSEL_W = 2,
    parameter int SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WBSEL_W-1:0] in_wbsel,
    input  logic               in_rd_wen,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    in_mem_rdata,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [REG_AW-1:0]  in_rd_waddr,
    input  logic [REG_AW-1:0]  in_rs1_raddr,
    input  logic [REG_AW-1:0]  in_rs2_raddr,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [WBSEL_W-1:0] out_wbsel,
    output logic               out_rd_wen,
    output logic [XLEN-1:0]    out_imm,
    output logic [XLEN-1:0]    out_mem_rdata,
    output logic [XLEN-1:0]    out_alu_result,
    output logic [XLEN-1:0]    out_pc,
    output logic [REG_AW-1:0]  out_rd_waddr,
    output logic [REG_AW-1:0]  out_rs1_raddr,
    output logic [REG_AW-1:0]  out_rs2_raddr,

    output logic [1:0]         occupancy
);

    localparam int   PW      = WBSEL_W + 1 + 4 * XLEN + 3 * REG_AW;
    localparam logic SKID_EN = (SKID != 0);

    // Entry state: main drives the outputs, skid holds the overflow entry.
    logic          r_main_valid;
    logic          r_skid_valid;
    logic [PW-1:0] r_main_pl;
    logic [PW-1:0] r_skid_pl;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_xfer;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_skid_move;
    logic          w_main_wen;
    logic [PW-1:0] w_in_pl;

    assign w_in_pl = {in_wbsel, in_rd_wen, in_imm, in_mem_rdata, in_alu_result,
                      in_pc, in_rd_waddr, in_rs1_raddr, in_rs2_raddr};

    generate
        if (SKID_EN) begin : g_skid_ready
            // Registered ready: while the skid entry is empty, one more
            // entry can always be absorbed, whatever out_ready does.
            assign w_in_ready = !r_skid_valid;
        end else begin : g_plain_ready
            assign w_in_ready = !r_main_valid || out_ready;
        end
    endgenerate

    assign w_accept = in_valid && w_in_ready && !flush;
    assign w_xfer   = r_main_valid && out_ready;

    // When the skid entry is full, in_ready is low. Because of that, a skid
    // move and an accept never happen in the same cycle.
    assign w_skid_move = SKID_EN && w_xfer && r_skid_valid && !flush;
    assign w_load_main = w_accept && (!r_main_valid || w_xfer);
    assign w_load_skid = SKID_EN && w_accept && r_main_valid && !w_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pl    <= '0;
            r_skid_pl    <= '0;
        end else begin
            if (flush) begin
                r_main_valid <= 1'b0;
            end else if (w_load_main || w_skid_move) begin
                r_main_valid <= 1'b1;
            end else if (w_xfer) begin
                r_main_valid <= 1'b0;
            end

            if (flush) begin
                r_skid_valid <= 1'b0;
            end else if (w_load_skid) begin
                r_skid_valid <= 1'b1;
            end else if (w_skid_move) begin
                r_skid_valid <= 1'b0;
            end

            // Payload only moves with an entry; liveness lives in the valid bits.
            if (w_skid_move) begin
                r_main_pl <= r_skid_pl;
            end else if (w_load_main) begin
                r_main_pl <= w_in_pl;
            end

            if (w_load_skid) begin
                r_skid_pl <= w_in_pl;
            end
        end
    end

    assign {out_wbsel, w_main_wen, out_imm, out_mem_rdata, out_alu_result,
            out_pc, out_rd_waddr, out_rs1_raddr, out_rs2_raddr} = r_main_pl;

    assign in_ready   = w_in_ready;
    assign out_valid  = r_main_valid;
    // x0 is hardwired to zero, so a write to it is dropped here.
    assign out_rd_wen = r_main_valid && w_main_wen && (out_rd_waddr != '0);
    assign occupancy  = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_m_rb_stage.sv
module tb_m_rb_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] mdat;
        logic [31:0] alu;
        logic [1:0]  wbsel;
        logic        wen;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid, out_ready, in_valid0, out_ready0;
    logic [1:0]  in_wbsel;
    logic        in_rd_wen;
    logic [31:0] in_imm, in_mem_rdata, in_alu_result, in_pc;
    logic [4:0]  in_rd_waddr, in_rs1_raddr, in_rs2_raddr;

    logic        in_ready, out_valid, out_rd_wen;
    logic [1:0]  out_wbsel, occupancy;
    logic [31:0] out_imm, out_mem_rdata, out_alu_result, out_pc;
    logic [4:0]  out_rd_waddr, out_rs1_raddr, out_rs2_raddr;

    logic        in_ready0, out_valid0, out_rd_wen0;
    logic [1:0]  out_wbsel0, occupancy0;
    logic [31:0] out_imm0, out_mem_rdata0, out_alu_result0, out_pc0;
    logic [4:0]  out_rd_waddr0, out_rs1_raddr0, out_rs2_raddr0;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   model_ok = 1'b0;
    ent_t q1[$];
    ent_t q0[$];

    always #5 clk = ~clk;

    m_rb_stage #(.XLEN(32), .REG_AW(5), .WBSEL_W(2), .SKID(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wbsel(in_wbsel), .in_rd_wen(in_rd_wen), .in_imm(in_imm),
        .in_mem_rdata(in_mem_rdata), .in_alu_result(in_alu_result), .in_pc(in_pc),
        .in_rd_waddr(in_rd_waddr), .in_rs1_raddr(in_rs1_raddr), .in_rs2_raddr(in_rs2_raddr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wbsel(out_wbsel), .out_rd_wen(out_rd_wen), .out_imm(out_imm),
        .out_mem_rdata(out_mem_rdata), .out_alu_result(out_alu_result), .out_pc(out_pc),
        .out_rd_waddr(out_rd_waddr), .out_rs1_raddr(out_rs1_raddr), .out_rs2_raddr(out_rs2_raddr),
        .occupancy(occupancy)
    );

    m_rb_stage #(.XLEN(32), .REG_AW(5), .WBSEL_W(2), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_wbsel(in_wbsel), .in_rd_wen(in_rd_wen), .in_imm(in_imm),
        .in_mem_rdata(in_mem_rdata), .in_alu_result(in_alu_result), .in_pc(in_pc),
        .in_rd_waddr(in_rd_waddr), .in_rs1_raddr(in_rs1_raddr), .in_rs2_raddr(in_rs2_raddr),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_wbsel(out_wbsel0), .out_rd_wen(out_rd_wen0), .out_imm(out_imm0),
        .out_mem_rdata(out_mem_rdata0), .out_alu_result(out_alu_result0), .out_pc(out_pc0),
        .out_rd_waddr(out_rd_waddr0), .out_rs1_raddr(out_rs1_raddr0), .out_rs2_raddr(out_rs2_raddr0),
        .occupancy(occupancy0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [31:0] alu,
                          input logic wen, input logic [4:0] rd);
        in_pc         = pc;
        in_imm        = pc ^ 32'h5A5A_0000;
        in_mem_rdata  = ~pc;
        in_alu_result = alu;
        in_wbsel      = pc[3:2];
        in_rd_wen     = wen;
        in_rd_waddr   = rd;
        in_rs1_raddr  = pc[6:2];
        in_rs2_raddr  = pc[8:4];
    endtask

    function automatic ent_t cur_ent();
        ent_t e;
        e.pc    = in_pc;
        e.imm   = in_imm;
        e.mdat  = in_mem_rdata;
        e.alu   = in_alu_result;
        e.wbsel = in_wbsel;
        e.wen   = in_rd_wen && (in_rd_waddr != 5'd0);
        e.rd    = in_rd_waddr;
        e.rs1   = in_rs1_raddr;
        e.rs2   = in_rs2_raddr;
        return e;
    endfunction

    task automatic cmp_ent(input string tag, input ent_t e,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] md, input logic [31:0] alu,
                           input logic [1:0] wb, input logic wen,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".imm"}, imm, e.imm);
        chk({tag, ".mem_rdata"}, md, e.mdat);
        chk({tag, ".alu"}, alu, e.alu);
        chk({tag, ".wbsel"}, wb, e.wbsel);
        chk({tag, ".rd_wen"}, wen, e.wen);
        chk({tag, ".rd"}, rd, e.rd);
        chk({tag, ".rs"}, {rs1, rs2}, {e.rs1, e.rs2});
    endtask

    // One clock: check control outputs against the model at the negedge,
    // advance the model for the coming edge, then return #1 after it.
    task automatic tick();
        bit   rdy1, rdy0;
        ent_t e;
        @(negedge clk);
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || out_ready0;
        if (model_ok) begin
            chk("s1.in_ready", in_ready, rdy1);
            chk("s1.occupancy", occupancy, q1.size());
            chk("s1.out_valid", out_valid, q1.size() != 0);
            chk("s0.in_ready", in_ready0, rdy0);
            chk("s0.occupancy", occupancy0, q0.size());
            chk("s0.out_valid", out_valid0, q0.size() != 0);
        end
        if (rst) begin
            q1.delete();
            q0.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (q1.size() != 0 && out_ready) begin
                e = q1.pop_front();
                cmp_ent("s1", e, out_pc, out_imm, out_mem_rdata, out_alu_result,
                        out_wbsel, out_rd_wen, out_rd_waddr, out_rs1_raddr, out_rs2_raddr);
            end
            if (flush) q1.delete();
            else if (in_valid && rdy1) q1.push_back(cur_ent());

            if (q0.size() != 0 && out_ready0) begin
                e = q0.pop_front();
                cmp_ent("s0", e, out_pc0, out_imm0, out_mem_rdata0, out_alu_result0,
                        out_wbsel0, out_rd_wen0, out_rd_waddr0, out_rs1_raddr0, out_rs2_raddr0);
            end
            if (flush) q0.delete();
            else if (in_valid0 && rdy0) q0.push_back(cur_ent());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a live input presented
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        in_valid0 = 1'b1; out_ready0 = 1'b1;
        set_in(32'h0000_0050, 32'h1111_1111, 1'b1, 5'd3);
        tick();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_rd_wen", out_rd_wen, 0);
        chk("rst.occupancy", occupancy, 0);
        chk("rst.in_ready", in_ready, 1);
        tick();
        rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        tick();
        chk("post_rst.out_pc", out_pc, 0);
        chk("post_rst.out_alu", out_alu_result, 0);
        chk("post_rst.out_valid0", out_valid0, 0);
        chk("post_rst.out_pc0", out_pc0, 0);

        // Streaming, one entry per cycle
        in_valid = 1'b1;
        set_in(32'h100, 32'hA000_0001, 1'b1, 5'd7);
        tick();
        chk("stream.pc0", out_pc, 32'h100);
        set_in(32'h104, 32'hA000_0002, 1'b1, 5'd8);
        tick();
        chk("stream.pc1", out_pc, 32'h104);
        set_in(32'h108, 32'hA000_0003, 1'b0, 5'd9);
        tick();
        chk("stream.pc2", out_pc, 32'h108);
        in_valid = 1'b0;
        tick();
        chk("stream.drained", out_valid, 0);

        // Skid stall: A accepted, B to skid, C held at the input
        in_valid = 1'b1;
        set_in(32'h200, 32'hB000_0000, 1'b1, 5'd10);
        tick();
        out_ready = 1'b0;
        set_in(32'h204, 32'hB000_0001, 1'b1, 5'd11);
        tick();
        set_in(32'h208, 32'hB000_0002, 1'b1, 5'd12);
        tick();
        chk("stall.occupancy", occupancy, 2);
        chk("stall.in_ready", in_ready, 0);
        chk("stall.head_pc", out_pc, 32'h200);
        tick();
        out_ready = 1'b1;
        tick();
        chk("stall.release_pc", out_pc, 32'h204);
        chk("stall.release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("stall.last_pc", out_pc, 32'h208);
        tick();
        tick();

        // x0 write suppression
        in_valid = 1'b1;
        set_in(32'h180, 32'hDEAD_BEEF, 1'b1, 5'd0);
        tick();
        chk("x0.out_valid", out_valid, 1);
        chk("x0.out_rd_wen", out_rd_wen, 0);
        chk("x0.alu", out_alu_result, 32'hDEAD_BEEF);
        set_in(32'h184, 32'hDEAD_BEEF, 1'b1, 5'd5);
        tick();
        chk("x5.out_rd_wen", out_rd_wen, 1);
        in_valid = 1'b0;
        tick();
        chk("idle.out_rd_wen", out_rd_wen, 0);

        // Flush with two held entries and one presented
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(32'h300, 32'hC000_0000, 1'b1, 5'd1);
        tick();
        set_in(32'h304, 32'hC000_0001, 1'b1, 5'd2);
        tick();
        set_in(32'h308, 32'hC000_0002, 1'b1, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2.out_valid", out_valid, 0);
        chk("flush2.occupancy", occupancy, 0);
        // Flush with room available: the presented entry must still be dropped
        in_valid = 1'b1;
        set_in(32'h310, 32'hC000_0003, 1'b1, 5'd4);
        tick();
        set_in(32'h314, 32'hC000_0004, 1'b1, 5'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1.occupancy", occupancy, 0);
        chk("flush1.in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        tick();

        // Non-skid variant: same-cycle backpressure
        in_valid0 = 1'b1; out_ready0 = 1'b0;
        set_in(32'h400, 32'hD000_0000, 1'b1, 5'd13);
        tick();
        chk("s0.full_pc", out_pc0, 32'h400);
        set_in(32'h404, 32'hD000_0001, 1'b1, 5'd14);
        #1;
        chk("s0.bp_ready", in_ready0, 0);
        out_ready0 = 1'b1;
        #1;
        chk("s0.pass_ready", in_ready0, 1);
        tick();
        chk("s0.replace_pc", out_pc0, 32'h404);
        in_valid0 = 1'b0;
        tick();
        chk("s0.drained", out_valid0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
